ps2_key_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_event_fifo.sv | 44 ++++
 rtl/ps2_key_decoder.sv | 137 +++++++++++++
 tb/tb_ps2_key_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 key decoder: frame FSM states, prefix bytes
// and the packed key-event layout carried through the event FIFO.
package ps2_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} ps2_state_t;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam int         EV_CODE_W = 8;
   localparam int         EV_W      = EV_CODE_W + 2;

   typedef struct packed {
      logic                 ext;
      logic                 brk;
      logic [EV_CODE_W-1:0] code;
   } ps2_event_t;

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_EXT) || (b == PS2_BRK);
   endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO; a push while full is accepted only if the head
// is popped in the same cycle.
module ps2_event_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit
// packets, folds E0/F0 prefixes into key events and queues them.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   input  logic       ev_ready,
   output logic       ev_valid,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       frame_err,
   output logic       overflow
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic            clk_s1, clk_s2, clk_prev, dat_s1, dat_s2, fall;
   ps2_state_t      state;
   logic [2:0]      bitcnt;
   logic [7:0]      shreg, byte_data;
   logic            par, byte_valid;
   logic [WD_W-1:0] wdog;
   logic            ext_pend, brk_pend;
   logic            push, pop, full, empty;
   ps2_event_t      push_ev, head_ev;

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         {clk_s1, clk_s2, clk_prev} <= 3'b111;
         {dat_s1, dat_s2}           <= 2'b11;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_dat;
         dat_s2   <= dat_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state      <= IDLE;
         bitcnt     <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         wdog       <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         wdog       <= (state == IDLE || fall) ? '0 : wdog + WD_W'(1);
         if (fall) begin
            case (state)
               IDLE: if (!dat_s2) begin
                  state  <= DATA;
                  bitcnt <= '0;
                  shreg  <= '0;
               end
               DATA: begin
                  shreg  <= {dat_s2, shreg[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= dat_s2;
                  state <= STOP;
               end
               STOP: begin
                  // odd parity: data ones plus parity bit must be odd
                  if (dat_s2 && ((^shreg) ^ par)) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shreg;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE && wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
         end
      end
   end

   assign push    = byte_valid & ~is_prefix(byte_data);
   assign pop     = ev_valid & ev_ready;
   assign push_ev = '{ext: ext_pend, brk: brk_pend, code: byte_data};

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (frame_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end else if (byte_valid) begin
            if (byte_data == PS2_EXT) ext_pend <= 1'b1;
            else if (byte_data == PS2_BRK) brk_pend <= 1'b1;
            else begin
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
            end
         end
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EV_W)) u_fifo (
      .clk   (CLOCK_50),
      .reset (Reset),
      .push  (push),
      .din   (push_ev),
      .pop   (pop),
      .dout  (head_ev),
      .full  (full),
      .empty (empty)
   );

   assign ev_valid = ~empty;
   assign ev_code  = head_ev.code;
   assign ev_ext   = head_ev.ext;
   assign ev_break = head_ev.brk;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: framing, prefixes, errors, timeout,
// overflow and mid-frame reset, with hand-computed expectations.
module tb_ps2_key_decoder;
   localparam int TO = 200;

   logic       CLOCK_50 = 1'b0;
   logic       Reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1, ev_ready = 1'b0;
   logic       ev_valid, ev_ext, ev_break, frame_err, overflow;
   logic [7:0] ev_code;
   int         n_vec = 0, n_err = 0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(8)) dut (
      .CLOCK_50 (CLOCK_50),
      .Reset    (Reset),
      .ps2_clk  (ps2_clk),
      .ps2_dat  (ps2_dat),
      .ev_ready (ev_ready),
      .ev_valid (ev_valid),
      .ev_code  (ev_code),
      .ev_ext   (ev_ext),
      .ev_break (ev_break),
      .frame_err(frame_err),
      .overflow (overflow)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge CLOCK_50); ps2_dat = b;
      repeat (5) @(negedge CLOCK_50);
      ps2_clk = 1'b0;
      repeat (10) @(negedge CLOCK_50);
      ps2_clk = 1'b1;
   endtask

   // Sends start/data/parity, then drops the clock for the stop bit and returns.
   task automatic send_open(input logic [7:0] d, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((~^d) ^ bad_par);
      @(negedge CLOCK_50); ps2_dat = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      ps2_clk = 1'b0;
   endtask

   task automatic finish_bit();
      repeat (10) @(negedge CLOCK_50);
      ps2_clk = 1'b1;
      repeat (5) @(negedge CLOCK_50);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic bad_par);
      send_open(d, bad_par);
      finish_bit();
   endtask

   task automatic pop_check(input string tag, input logic [7:0] code, input logic ext, input logic brk);
      chk({tag, "_valid"}, 32'(ev_valid), 32'(1));
      chk({tag, "_event"}, {22'd0, ev_ext, ev_break, ev_code}, {22'd0, ext, brk, code});
      @(negedge CLOCK_50); ev_ready = 1'b1;
      @(posedge CLOCK_50); #1;
      ev_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end

   initial begin
      int k, hit, pulses;
      repeat (3) @(posedge CLOCK_50);
      #1;
      chk("rst_valid", 32'(ev_valid), 0);
      chk("rst_fields", {22'd0, ev_ext, ev_break, ev_code}, 0);
      chk("rst_err_ovf", {30'd0, frame_err, overflow}, 0);
      @(negedge CLOCK_50); Reset = 1'b0;
      repeat (3) @(negedge CLOCK_50);

      // single make code, consumer always ready: latency and pop
      ev_ready = 1'b1;
      send_open(8'h1C, 1'b0);
      repeat (3) @(posedge CLOCK_50);
      #1 chk("lat_early", 32'(ev_valid), 0);
      @(posedge CLOCK_50); #1;
      chk("lat_on", 32'(ev_valid), 1);
      chk("make_1c", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, 2'b00, 8'h1C});
      @(posedge CLOCK_50); #1;
      chk("pop_fall", 32'(ev_valid), 0);
      finish_bit();
      ev_ready = 1'b0;

      // F0 1C
      send_byte(8'hF0, 1'b0);
      chk("brk_prefix_quiet", 32'(ev_valid), 0);
      send_byte(8'h1C, 1'b0);
      pop_check("brk_1c", 8'h1C, 1'b0, 1'b1);

      // E0 F0 75
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      chk("ext_prefix_quiet", 32'(ev_valid), 0);
      send_byte(8'h75, 1'b0);
      pop_check("extbrk_75", 8'h75, 1'b1, 1'b1);
      chk("extbrk_drained", 32'(ev_valid), 0);

      // bad parity: one-cycle error pulse, no event, prefixes work afterwards
      send_open(8'h1C, 1'b1);
      repeat (2) @(posedge CLOCK_50);
      #1 chk("err_early", 32'(frame_err), 0);
      @(posedge CLOCK_50); #1 chk("err_pulse", 32'(frame_err), 1);
      @(posedge CLOCK_50); #1 chk("err_clear", 32'(frame_err), 0);
      finish_bit();
      chk("err_no_event", 32'(ev_valid), 0);
      send_byte(8'hE0, 1'b0);
      send_byte(8'h75, 1'b0);
      pop_check("post_err_ext", 8'h75, 1'b1, 1'b0);

      // E0, bad frame, 75: the error drops the pending prefix
      send_byte(8'hE0, 1'b0);
      send_byte(8'h33, 1'b1);
      send_byte(8'h75, 1'b0);
      pop_check("err_clears_ext", 8'h75, 1'b0, 1'b0);

      // timeout: start + 5 data bits, clock left idle
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      @(negedge CLOCK_50); ps2_dat = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      ps2_clk = 1'b0;
      hit = 0;
      k = 0;
      while (hit == 0 && k < 2 * TO) begin
         @(posedge CLOCK_50); #1;
         k++;
         if (k == 10) ps2_clk = 1'b1;
         if (frame_err) hit = k;
      end
      chk("timeout_at", 32'(hit), 32'(TO + 3));
      @(posedge CLOCK_50); #1 chk("timeout_pulse_1", 32'(frame_err), 0);
      chk("timeout_no_event", 32'(ev_valid), 0);
      ps2_dat = 1'b1;
      send_byte(8'h29, 1'b0);
      pop_check("after_timeout", 8'h29, 1'b0, 1'b0);

      // overflow: 9 codes into an 8-deep FIFO with no consumer
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
      chk("ovf_not_yet", 32'(overflow), 0);
      send_byte(8'h09, 1'b0);
      chk("ovf_set", 32'(overflow), 1);
      for (int i = 1; i <= 8; i++) pop_check($sformatf("drain_%0d", i), 8'(i), 1'b0, 1'b0);
      chk("drain_empty", 32'(ev_valid), 0);
      chk("ovf_sticky", 32'(overflow), 1);

      // reset after 4 data bits: silent abandon, then normal decode
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      @(negedge CLOCK_50); Reset = 1'b1;
      repeat (2) @(posedge CLOCK_50);
      #1;
      chk("mid_rst_outs", {26'd0, ev_valid, ev_ext, ev_break, frame_err, overflow, 1'b0}, 0);
      chk("mid_rst_code", 32'(ev_code), 0);
      @(negedge CLOCK_50); Reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < TO + 20; i++) begin
         @(posedge CLOCK_50); #1;
         if (frame_err) pulses++;
      end
      chk("mid_rst_no_err", 32'(pulses), 0);
      send_byte(8'h5A, 1'b0);
      pop_check("post_rst_5a", 8'h5A, 1'b0, 1'b0);
      chk("post_rst_empty", 32'(ev_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
